// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// packing width and the per-state status decode used by the FSM outputs.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic in_ready;
    logic cpu_hold;
    logic done;
    logic error;
  } status_t;

  // Maps a state to the status outputs it presents while resident.
  function automatic status_t status_of(input state_t s);
    status_t st;
    st.in_ready = (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    st.cpu_hold = (s != DONE);
    st.done     = (s == DONE);
    st.error    = (s == ERR);
    return st;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer for the instruction-memory loader.
// Bytes shift in from the top so the first byte of a group lands in [7:0];
// a completed word is presented on word_data with a one-cycle word_valid.
// word_data only changes when a word completes, so it stays stable between
// strobes.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word_data
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shift_reg;
  logic        word_complete;

  assign word_complete = byte_valid && !clear && (lane == LAST_LANE);

  // Lane counter and partial-word shift register; a stall simply holds both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane      <= 2'd0;
      shift_reg <= 32'd0;
    end else if (clear) begin
      lane      <= 2'd0;
      shift_reg <= 32'd0;
    end else if (byte_valid) begin
      lane      <= lane + 2'd1;
      shift_reg <= {byte_data, shift_reg[31:8]};
    end
  end

  // Registers the completed word and its one-cycle strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else begin
      word_valid <= word_complete;
      if (word_complete) begin
        word_data <= {byte_data, shift_reg[31:8]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream,
// packs it into 32-bit words and writes them to instruction memory while
// holding the CPU in reset. Defining LOADER_CHECKSUM_EN adds a trailing
// XOR checksum byte that must match before the load is declared done.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  state_t          state;
  state_t          state_n;
  logic            accept;
  logic            take;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [15:0]     len_new;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      lane;
  logic            last_byte;
  logic            pack_valid;

  assign accept     = in_valid && in_ready;
  assign take       = accept && !start;
  assign len_new    = {in_data, len_lo};
  assign last_byte  = (lane == LAST_LANE) && (16'(word_cnt) == (len - 16'd1));
  assign pack_valid = take && (state == DATA);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CHECK;

  logic [7:0] csum;

  // Running XOR of both length bytes and every payload byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= 8'd0;
    end else if (start) begin
      csum <= 8'd0;
    end else if (take && ((state == LEN_LO) || (state == LEN_HI) || (state == DATA))) begin
      csum <= csum ^ in_data;
    end
  end
`else
  localparam state_t AFTER_LOAD = DONE;
`endif

  // Next-state decode; start overrides everything, including a byte in flight.
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = LEN_LO;
    end else begin
      case (state)
        LEN_LO: begin
          if (accept) state_n = LEN_HI;
        end
        LEN_HI: begin
          if (accept) begin
            if (len_new > 16'(DEPTH)) begin
              state_n = ERR;
            end else if (len_new == 16'd0) begin
              state_n = AFTER_LOAD;
            end else begin
              state_n = DATA;
            end
          end
        end
        DATA: begin
          if (accept && last_byte) state_n = AFTER_LOAD;
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) state_n = (in_data == csum) ? DONE : ERR;
        end
`endif
        default: begin
          state_n = state;
        end
      endcase
    end
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_n;
      {in_ready, cpu_hold, done, error} <= status_of(state_n);
    end
  end

  // Length capture, word counter and write address for the next strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo    <= 8'd0;
      len       <= 16'd0;
      word_cnt  <= '0;
      imem_addr <= '0;
    end else if (start) begin
      len_lo   <= 8'd0;
      len      <= 16'd0;
      word_cnt <= '0;
    end else if (take) begin
      case (state)
        LEN_LO: len_lo <= in_data;
        LEN_HI: len    <= len_new;
        DATA: begin
          if (lane == LAST_LANE) begin
            imem_addr <= word_cnt[ADDR_W-1:0];
            word_cnt  <= word_cnt + 1'b1;
          end
        end
        default: begin
          len <= len;
        end
      endcase
    end
  end

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .lane       (lane),
    .word_valid (imem_we),
    .word_data  (imem_wdata)
  );

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction memory words.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the word-address width, with 2**ADDR_W >= DEPTH.
REQ-003 SHALL have the port clk  input  1  system clock, with all state on the rising edge.
REQ-004 SHALL have the port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have the port start  input  1  one-cycle pulse that begins or restarts a program load.
REQ-006 SHALL have the port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have the port in_data  input  8  stream byte.
REQ-008 SHALL have the port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have the port imem_we  output  1  instruction memory write enable.
REQ-010 SHALL have the port imem_addr  output  ADDR_W  instruction memory word address.
REQ-011 SHALL have the port imem_wdata  output  32  instruction word.
REQ-012 SHALL have the port cpu_hold  output  1  holds the CPU program counter in reset while high.
REQ-013 SHALL have the port done  output  1  load completed successfully (level).
REQ-014 SHALL have the port error  output  1  load failed (level).

Function
REQ-015 SHALL implement the states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERR.
REQ-016 SHALL accept a byte only when in_valid and in_ready are both high in the same cycle.
REQ-017 SHALL drive in_ready high exactly in LEN_LO, LEN_HI, DATA and CHECK, and low in all other states.
REQ-018 SHALL move from any state to LEN_LO on start, clearing the byte count, word count, done and error; a start that coincides with an accepted byte discards that byte.
REQ-019 SHALL read the stream as a 16-bit word count N (low byte first), followed by 4*N payload bytes.
REQ-020 SHALL pack payload bytes little-endian: the first byte of each group goes to wdata[7:0] and the fourth to wdata[31:24].
REQ-021 SHALL pulse imem_we for one cycle in the cycle after the 4th byte of a word is accepted.
REQ-022 SHALL set imem_addr during that pulse to the word index (0..N-1) and imem_wdata to the packed word.
REQ-023 SHALL keep imem_addr and imem_wdata stable outside write pulses.
REQ-024 SHALL treat N > DEPTH as an error: on acceptance of the LEN_HI byte, go to ERR and issue no writes.
REQ-025 SHALL, when N == 0, go directly from LEN_HI to CHECK (macro defined) or to DONE (macro undefined).
REQ-026 SHALL, after the last payload byte is accepted, go to CHECK (macro defined) or to DONE (macro undefined); the final write pulse still occurs in the following cycle.
REQ-027 SHALL hold DONE with done=1, cpu_hold=0 and error=0 until start or reset.
REQ-028 SHALL hold ERR with error=1, done=0 and cpu_hold=1 until start or reset.
REQ-029 SHALL keep cpu_hold=1 in every state except DONE.
REQ-030 SHALL ignore in_valid while in_ready is low; a stall of any length inside a word SHALL not corrupt the partially packed word.

Reset
REQ-031 SHALL, while reset is low, immediately force state=IDLE, cpu_hold=1, done=0, error=0, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, and clear all counters.
REQ-032 SHALL abandon a load in progress when reset is asserted mid-load; words already written are not rolled back.

Configuration
REQ-033 SHALL, with LOADER_CHECKSUM_EN defined, expect one trailing byte in CHECK equal to the XOR of both length bytes and all payload bytes, going to DONE on a match and to ERR on a mismatch.
REQ-034 SHALL, with LOADER_CHECKSUM_EN undefined, never enter CHECK, omit the XOR register, and not consume any trailing byte.

Structure
REQ-035 SHALL place the state enum type and the constant BYTES_PER_WORD=4 in the shared package loader_pkg.
REQ-036 SHALL implement byte-to-word packing (2-bit lane counter, 32-bit shift register, word_valid strobe) in one sub-module, byte_packer; the FSM and address counter stay in imem_loader.

Verification
REQ-037 SHALL cover a basic load: start, then bytes 02 00 | 01 02 03 04 | AA BB CC DD (no gaps) -> writes 0x04030201 to address 0 and 0xDDCCBBAA to address 1, then done=1 and cpu_hold=0.
REQ-038 SHALL cover an oversize load: DEPTH=64 with length bytes 41 00 -> error=1, cpu_hold=1, imem_we never asserted, in_ready=0.
REQ-039 SHALL cover a stalled load: same stream as REQ-037 with in_valid low for 5 cycles between bytes 2 and 3 -> identical writes and final outputs.
REQ-040 SHALL cover a restart: start again after 3 payload bytes, followed by a fresh 01 00 11 22 33 44 stream -> a single write of 0x44332211 at address 0, then done=1.
REQ-041 SHALL cover a checksum mismatch (LOADER_CHECKSUM_EN defined): stream 01 00 01 02 03 04 plus trailing byte 00 (correct value 05) -> the write to address 0 occurs, then error=1 and done=0.
REQ-042 SHALL cover reset mid-load: reset asserted low during DATA -> all outputs take their REQ-031 values in the same cycle, and the next start performs a normal load.
